// File: rtl/int8pe_pkg.sv
// Shared types and constants for the int8 PE requantization drain stage.
package int8pe_pkg;

  localparam int unsigned ACC_W   = 32;
  localparam int unsigned PROD_W  = 48;
  localparam int unsigned SCALE_W = 16;
  localparam int unsigned SHIFT_W = 5;
  localparam int unsigned Q_W     = 8;
  localparam int          Q_MIN   = -128;
  localparam int          Q_MAX   = 127;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_FLUSH,
    ST_CAPT
  } state_t;

  typedef struct packed {
    logic signed [SCALE_W-1:0] scale;
    logic [SHIFT_W-1:0]        shift;
  } rq_cfg_t;

endpackage

// File: rtl/int8pe_requant_if.sv
// Job request and result handshake bundle of the requant drain stage.
interface int8pe_requant_if #(
  parameter int unsigned LEN_W = 16
);
  import int8pe_pkg::*;

  logic                      job_valid;
  logic                      job_ready;
  logic [LEN_W-1:0]          job_len;
  logic signed [SCALE_W-1:0] job_scale;
  logic [SHIFT_W-1:0]        job_shift;
  logic                      res_valid;
  logic                      res_ready;
  logic signed [Q_W-1:0]     res_data;

  modport master (
    output job_valid, job_len, job_scale, job_shift, res_ready,
    input  job_ready, res_valid, res_data
  );

  modport slave (
    input  job_valid, job_len, job_scale, job_shift, res_ready,
    output job_ready, res_valid, res_data
  );

endinterface

// File: rtl/int8pe_res_fifo.sv
// Synchronous result FIFO with a registered head word and occupancy count.
module int8pe_res_fifo #(
  parameter  int unsigned W     = 8,
  parameter  int unsigned DEP   = 2,
  localparam int unsigned PTR_W = $clog2(DEP),
  localparam int unsigned CNT_W = $clog2(DEP + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     wdata,
  input  logic             ready,
  output logic [W-1:0]     rdata,
  output logic             valid,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0]     mem [DEP];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_n;
  logic             do_pop;
  logic             do_push;

  assign do_pop  = valid && ready;
  assign do_push = push && ((count < CNT_W'(DEP)) || do_pop);

  always_comb begin
    count_n = count;
    case ({do_push, do_pop})
      2'b10:   count_n = count + CNT_W'(1);
      2'b01:   count_n = count - CNT_W'(1);
      default: count_n = count;
    endcase
  end

  // Head register follows whichever word becomes the oldest entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
      rdata  <= '0;
    end else begin
      count <= count_n;
      valid <= (count_n != '0);
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && ((count == '0) || (do_pop && (count == CNT_W'(1)))))
        rdata <= wdata;
      else if (do_pop && (count > CNT_W'(1)))
        rdata <= mem[rd_ptr + PTR_W'(1)];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/int8pe_requant.sv
// Drain stage: tracks a PE job, waits out the PE pipeline, captures and requantizes the
// accumulator to int8, and buffers results for a valid/ready consumer.
module int8pe_requant
  import int8pe_pkg::*;
#(
  parameter int unsigned PE_LAT   = 6,
  parameter int unsigned LEN_W    = 16,
  parameter int unsigned FIFO_DEP = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  int8pe_requant_if.slave         bus,
  input  logic                    beat_valid,
  input  logic signed [ACC_W-1:0] pe_acc,
  output logic                    pe_clr,
  output logic                    busy
);

  localparam int unsigned LAT_W = $clog2(PE_LAT + 1);
  localparam int unsigned CNT_W = $clog2(FIFO_DEP + 1);
  localparam int unsigned OCC_W = CNT_W + 2;
  localparam logic signed [PROD_W-1:0] SAT_HI = PROD_W'(Q_MAX);
  localparam logic signed [PROD_W-1:0] SAT_LO = PROD_W'(Q_MIN);

  state_t                    state, state_n;
  logic [LEN_W-1:0]          len_q, beat_cnt;
  logic [LAT_W-1:0]          lat_cnt;
  rq_cfg_t                   cfg_q;
  logic [SHIFT_W-1:0]        s1_shift;
  logic                      s1_vld, s2_vld;
  logic signed [PROD_W-1:0]  s1_prod, rnd_c, shr_c;
  logic signed [Q_W-1:0]     s2_res, q_c;
  logic [CNT_W-1:0]          fifo_count;
  logic [OCC_W-1:0]          occ;
  logic                      job_hs, last_beat, lat_done, capt;

  assign job_hs    = bus.job_valid && bus.job_ready;
  assign last_beat = (state == ST_ACCUM) && beat_valid && ((beat_cnt + LEN_W'(1)) == len_q);
  assign lat_done  = (lat_cnt == LAT_W'(PE_LAT - 1));
  // Results in the pipe or being captured hold a FIFO slot before they arrive.
  assign occ       = OCC_W'(fifo_count) + OCC_W'(s1_vld) + OCC_W'(s2_vld) + OCC_W'(capt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (job_hs)    state_n = ST_ACCUM;
      ST_ACCUM: if (last_beat) state_n = ST_FLUSH;
      ST_FLUSH: if (lat_done)  state_n = ST_CAPT;
      ST_CAPT:                 state_n = ST_IDLE;
      default:                 state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    busy          = 1'b0;
    pe_clr        = 1'b0;
    capt          = 1'b0;
    bus.job_ready = 1'b0;
    busy          = (state != ST_IDLE);
    capt          = (state == ST_CAPT);
    pe_clr        = capt;
    bus.job_ready = !rst && (state == ST_IDLE) && (occ < OCC_W'(FIFO_DEP));
  end

  // Job configuration and beat/latency counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q    <= '0;
      beat_cnt <= '0;
      lat_cnt  <= '0;
      cfg_q    <= '0;
    end else begin
      if (job_hs) begin
        len_q       <= (bus.job_len == '0) ? LEN_W'(1) : bus.job_len;
        cfg_q.scale <= bus.job_scale;
        cfg_q.shift <= bus.job_shift;
        beat_cnt    <= '0;
      end else if ((state == ST_ACCUM) && beat_valid) begin
        beat_cnt <= beat_cnt + LEN_W'(1);
      end
      if (last_beat)              lat_cnt <= '0;
      else if (state == ST_FLUSH) lat_cnt <= lat_cnt + LAT_W'(1);
    end
  end

  // Round half up, arithmetic shift, saturate to int8.
  always_comb begin
    rnd_c = '0;
    if (s1_shift != '0) rnd_c = PROD_W'(1) << (s1_shift - SHIFT_W'(1));
    shr_c = (s1_prod + rnd_c) >>> s1_shift;
    if (shr_c > SAT_HI)      q_c = Q_W'(Q_MAX);
    else if (shr_c < SAT_LO) q_c = Q_W'(Q_MIN);
    else                     q_c = Q_W'(shr_c);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld   <= 1'b0;
      s2_vld   <= 1'b0;
      s1_prod  <= '0;
      s1_shift <= '0;
      s2_res   <= '0;
    end else begin
      s1_vld <= capt;
      s2_vld <= s1_vld;
      if (capt) begin
        s1_prod  <= PROD_W'($signed(pe_acc)) * PROD_W'($signed(cfg_q.scale));
        s1_shift <= cfg_q.shift;
      end
      if (s1_vld) s2_res <= q_c;
    end
  end

  int8pe_res_fifo #(
    .W   (Q_W),
    .DEP (FIFO_DEP)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s2_vld),
    .wdata (s2_res),
    .ready (bus.res_ready),
    .rdata (bus.res_data),
    .valid (bus.res_valid),
    .count (fifo_count)
  );

endmodule
